// File: rtl/monitor_cmd_if.sv
// Host-facing bundle for monitor_cmd_engine: receive byte stream, transmit
// handshake, UART flow control and the read-back request/acknowledge pair.
interface monitor_cmd_if #(
    parameter int MAX_PAYLOAD = 16
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     uart_rts;
    logic                     uart_cts;
    logic                     rd_req;
    logic                     rd_ack;
    logic [8*MAX_PAYLOAD-1:0] rd_data;

    // Host side: feeds bytes, accepts transmit bytes, answers read requests.
    modport master (
        output rx_data, rx_valid, tx_ready, uart_rts, rd_ack, rd_data,
        input  tx_data, tx_valid, uart_cts, rd_req
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready, uart_rts, rd_ack, rd_data,
        output tx_data, tx_valid, uart_cts, rd_req
    );
endinterface

// File: rtl/monitor_cmd_engine.sv
// Byte-oriented monitor command engine: command/length header, write payload capture,
// read-back transmit. Optional inter-byte timeout enabled by defining MONITOR_TIMEOUT_EN.
module monitor_cmd_engine #(
    parameter int CMD_BYTES      = 1,
    parameter int LEN_BYTES      = 1,
    parameter int MAX_PAYLOAD    = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk50,
    input  logic                     reset,
    monitor_cmd_if.slave             bus,
    output logic                     cmd_rw,
    output logic [8*CMD_BYTES-2:0]   cmd_id,
    output logic [8*LEN_BYTES-1:0]   data_size,
    output logic [8*MAX_PAYLOAD-1:0] cmd_data,
    output logic                     wr_strobe,
    output logic [2:0]               state,
    output logic                     err,
    output logic [1:0]               err_code
);
    localparam int CW = 8*CMD_BYTES;
    localparam int LW = 8*LEN_BYTES;
    localparam int IW = $clog2(MAX_PAYLOAD + 1);
    localparam int BW = $clog2(8*MAX_PAYLOAD);
    localparam logic [31:0] MAX_U = MAX_PAYLOAD;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_OVR = 2'd2;
    localparam logic [1:0] ERR_TO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        LEN    = 3'd2,
        WRITE  = 3'd3,
        RD_REQ = 3'd4,
        READ   = 3'd5,
        DRAIN  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cmd_sh;
    logic [1:0]    hdr_cnt;
    logic [IW-1:0] idx;
    logic [LW-1:0] drain_cnt;

    logic          strobe_d;
    logic          err_d;
    logic [1:0]    err_cause;
    logic [CW-1:0] cmd_shift;
    logic [LW-1:0] len_next;
    logic [BW-1:0] byte_base;
    logic          cmd_last, len_last, len_big, idx_last, drain_last;
    logic          tx_fire;
    logic          timeout_hit;

    // Header fields arrive MSB-byte first, so each new byte enters at the bottom.
    assign cmd_shift  = (cmd_sh << 8) | CW'(bus.rx_data);
    assign len_next   = (data_size << 8) | LW'(bus.rx_data);
    assign cmd_last   = (hdr_cnt == 2'(CMD_BYTES - 1));
    assign len_last   = (hdr_cnt == 2'(LEN_BYTES - 1));
    assign len_big    = (32'(len_next) > MAX_U);
    assign idx_last   = (32'(idx) == 32'(data_size) - 32'd1);
    assign drain_last = (drain_cnt == data_size - LW'(1));
    assign byte_base  = BW'({idx, 3'b000});

    assign bus.tx_valid = (state_q == READ);
    assign bus.tx_data  = bus.tx_valid ? cmd_data[byte_base +: 8] : 8'd0;
    assign bus.rd_req   = (state_q == RD_REQ);
    assign bus.uart_cts = !(state_q inside {CMD, LEN, WRITE, DRAIN});
    assign tx_fire      = bus.tx_valid && bus.tx_ready;
    assign state        = state_q;

`ifdef MONITOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          timed;

    assign timed       = (state_q inside {CMD, LEN, WRITE, DRAIN});
    assign timeout_hit = timed && !bus.rx_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Any sign of life restarts the inter-byte window.
    always_ff @(posedge clk50) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (!timed || bus.rx_valid || tx_fire || (state_d != state_q)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        err_cause = err_code;
        case (state_q)
            IDLE: begin
                if (!bus.uart_rts) state_d = CMD;
            end
            CMD: begin
                if (bus.rx_valid && cmd_last) state_d = LEN;
            end
            LEN: begin
                if (bus.rx_valid && len_last) begin
                    if (len_next == '0) begin
                        state_d = IDLE;
                    end else if (len_big) begin
                        err_d     = 1'b1;
                        err_cause = ERR_LEN;
                        state_d   = cmd_rw ? DRAIN : IDLE;
                    end else begin
                        state_d = cmd_rw ? WRITE : RD_REQ;
                    end
                end
            end
            WRITE: begin
                if (bus.rx_valid && idx_last) begin
                    state_d  = IDLE;
                    strobe_d = 1'b1;
                end
            end
            DRAIN: begin
                if (bus.rx_valid && drain_last) state_d = IDLE;
            end
            RD_REQ: begin
                if (bus.rd_ack) state_d = READ;
            end
            READ: begin
                if (tx_fire && idx_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The host must stay quiet while a read is in flight; its bytes are dropped.
        if ((state_q == RD_REQ || state_q == READ) && bus.rx_valid) begin
            err_d     = 1'b1;
            err_cause = ERR_OVR;
        end

        if (timeout_hit) begin
            state_d   = IDLE;
            strobe_d  = 1'b0;
            err_d     = 1'b1;
            err_cause = ERR_TO;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            cmd_sh    <= '0;
            hdr_cnt   <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            cmd_rw    <= 1'b0;
            cmd_id    <= '0;
            data_size <= '0;
            cmd_data  <= '0;
            wr_strobe <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            wr_strobe <= strobe_d;
            err       <= err_d;
            err_code  <= err_cause;
            case (state_q)
                CMD: begin
                    if (bus.rx_valid) begin
                        cmd_sh <= cmd_shift;
                        if (cmd_last) begin
                            {cmd_rw, cmd_id} <= cmd_shift;
                            hdr_cnt          <= '0;
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                LEN: begin
                    if (bus.rx_valid) begin
                        data_size <= len_next;
                        if (len_last) begin
                            hdr_cnt   <= '0;
                            idx       <= '0;
                            drain_cnt <= '0;
                            if (state_d == WRITE) cmd_data <= '0;
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.rx_valid) begin
                        cmd_data[byte_base +: 8] <= bus.rx_data;
                        idx                      <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.rx_valid) drain_cnt <= drain_cnt + 1'b1;
                end
                RD_REQ: begin
                    if (bus.rd_ack) begin
                        cmd_data <= bus.rd_data;
                        idx      <= '0;
                    end
                end
                READ: begin
                    if (tx_fire) idx <= idx + 1'b1;
                end
                default: ;
            endcase
            // Every return to IDLE, normal or aborted, leaves the counters ready for the next header.
            if (state_d == IDLE) begin
                idx       <= '0;
                hdr_cnt   <= '0;
                drain_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_monitor_cmd_engine.sv
// Randomised self-checking bench for monitor_cmd_engine, compared against a
// transaction-level model of the command protocol.
module tb_monitor_cmd_engine;
    localparam int MAXP   = 16;
    localparam int TO_CYC = 100;
    typedef logic [127:0] val_t;

    logic clk50 = 1'b0;
    logic reset;
    always #10 clk50 = ~clk50;

    monitor_cmd_if #(.MAX_PAYLOAD(MAXP)) bus ();

    logic            cmd_rw;
    logic [6:0]      cmd_id;
    logic [7:0]      data_size;
    logic [8*MAXP-1:0] cmd_data;
    logic            wr_strobe;
    logic [2:0]      state;
    logic            err;
    logic [1:0]      err_code;

    monitor_cmd_engine #(
        .CMD_BYTES(1), .LEN_BYTES(1), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk50(clk50), .reset(reset), .bus(bus),
        .cmd_rw(cmd_rw), .cmd_id(cmd_id), .data_size(data_size), .cmd_data(cmd_data),
        .wr_strobe(wr_strobe), .state(state), .err(err), .err_code(err_code)
    );

    int n_checks    = 0;
    int n_fail      = 0;
    int strobe_seen = 0;
    int err_seen    = 0;
    logic [7:0] tx_q[$];

    // Transaction-level model of the visible command registers.
    logic       exp_rw;
    logic [6:0] exp_id;
    logic [7:0] exp_size;
    logic [7:0] exp_buf[MAXP];
    logic [1:0] exp_code;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic val_t pack_buf();
        val_t v = '0;
        for (int i = 0; i < MAXP; i++) v[8*i +: 8] = exp_buf[i];
        return v;
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3 == 2);
        return 1'($urandom & 1);
    endfunction

    task automatic model_reset();
        exp_rw   = 1'b0;
        exp_id   = '0;
        exp_size = '0;
        exp_code = '0;
        for (int i = 0; i < MAXP; i++) exp_buf[i] = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    // Transfer log, pulse counters and the hold-while-stalled rule on the transmit side.
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    always @(negedge clk50) begin
        if (hold_pend) begin
            check("tx_hold_valid", val_t'(bus.tx_valid), val_t'(1));
            check("tx_hold_data", val_t'(bus.tx_data), val_t'(hold_data));
        end
        hold_pend = bus.tx_valid && !bus.tx_ready;
        hold_data = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
        if (wr_strobe) begin
            strobe_seen++;
            check("strobe_in_idle", val_t'(state), val_t'(0));
        end
        if (err) err_seen++;
    end

    task automatic send(input logic [7:0] b, input int gapmax);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(gapmax, 0)) tick();
    endtask

    task automatic open_cmd();
        int n = 0;
        bus.uart_rts = 1'b0;
        while (bus.uart_cts !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check("cts_low", val_t'(bus.uart_cts), val_t'(0));
        bus.uart_rts = 1'b1;
    endtask

    task automatic check_regs(input int want_s, input int want_e, input int s0, input int e0);
        check("state_idle", val_t'(state), val_t'(0));
        check("strobe_count", val_t'(strobe_seen - s0), val_t'(want_s));
        check("err_count", val_t'(err_seen - e0), val_t'(want_e));
        check("err_code", val_t'(err_code), val_t'(exp_code));
        check("cmd_rw", val_t'(cmd_rw), val_t'(exp_rw));
        check("cmd_id", val_t'(cmd_id), val_t'(exp_id));
        check("data_size", val_t'(data_size), val_t'(exp_size));
        check("cmd_data", val_t'(cmd_data), pack_buf());
    endtask

    task automatic check_reset_values();
        check("rst_state", val_t'(state), val_t'(0));
        check("rst_cts", val_t'(bus.uart_cts), val_t'(1));
        check("rst_tx_valid", val_t'(bus.tx_valid), val_t'(0));
        check("rst_tx_data", val_t'(bus.tx_data), val_t'(0));
        check("rst_rd_req", val_t'(bus.rd_req), val_t'(0));
        check("rst_wr_strobe", val_t'(wr_strobe), val_t'(0));
        check("rst_err", val_t'(err), val_t'(0));
        check("rst_err_code", val_t'(err_code), val_t'(0));
        check("rst_cmd_rw", val_t'(cmd_rw), val_t'(0));
        check("rst_cmd_id", val_t'(cmd_id), val_t'(0));
        check("rst_data_size", val_t'(data_size), val_t'(0));
        check("rst_cmd_data", val_t'(cmd_data), val_t'(0));
    endtask

    // One complete command; payload supplies write bytes or the read-back image.
    task automatic run_txn(input logic [7:0] cmd, input int len, input int rmode,
                           input bit inject, input int gapmax, input val_t payload);
        int want_s = 0;
        int want_e = 0;
        int s0 = strobe_seen;
        int e0 = err_seen;
        int n;
        open_cmd();
        send(cmd, gapmax);
        exp_rw = cmd[7];
        exp_id = cmd[6:0];
        send(8'(len), gapmax);
        exp_size = 8'(len);
        if (len == 0) begin
            want_s = 0;
        end else if (len > MAXP) begin
            want_e   = 1;
            exp_code = 2'd1;
            if (cmd[7]) for (int i = 0; i < len; i++) send(8'($urandom), gapmax);
        end else if (cmd[7]) begin
            for (int i = 0; i < MAXP; i++) exp_buf[i] = 8'h00;
            for (int i = 0; i < len; i++) begin
                exp_buf[i] = payload[8*i +: 8];
                send(exp_buf[i], gapmax);
            end
            want_s = 1;
        end else begin
            n = 0;
            while (bus.rd_req !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            check("rd_req_high", val_t'(bus.rd_req), val_t'(1));
            check("cts_in_read", val_t'(bus.uart_cts), val_t'(1));
            if (inject) begin
                bus.rx_data  = 8'($urandom);
                bus.rx_valid = 1'b1;
                tick();
                bus.rx_valid = 1'b0;
                want_e   = 1;
                exp_code = 2'd2;
            end
            tx_q.delete();
            bus.rd_data  = payload;
            bus.rd_ack   = 1'b1;
            bus.tx_ready = ready_for(rmode, 0);
            tick();
            bus.rd_ack = 1'b0;
            n = 1;
            while (state != 3'd0 && n < 300) begin
                bus.tx_ready = ready_for(rmode, n);
                tick();
                n++;
            end
            bus.tx_ready = 1'b0;
            for (int i = 0; i < MAXP; i++) exp_buf[i] = payload[8*i +: 8];
            check("tx_count", val_t'(tx_q.size()), val_t'(len));
            for (int i = 0; i < len && i < tx_q.size(); i++)
                check("tx_byte", val_t'(tx_q[i]), val_t'(payload[8*i +: 8]));
            if (rmode == 0) check("tx_no_bubble", val_t'(n), val_t'(len + 1));
        end
        repeat (2) tick();
        check_regs(want_s, want_e, s0, e0);
    endtask

    initial begin
        int   kind;
        int   len;
        logic rw;
        int   s0;
        int   e0;
        int   n;
        val_t pl;

        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        bus.uart_rts = 1'b1;
        bus.rd_ack   = 1'b0;
        bus.rd_data  = '0;
        model_reset();
        repeat (3) tick();
        check_reset_values();
        reset = 1'b0;
        tick();
        check("idle_cts_high", val_t'(bus.uart_cts), val_t'(1));

        // Write of three bytes, then reads with free-running and throttled tx_ready.
        run_txn(8'h85, 3, 0, 1'b0, 0, val_t'(24'hCCBBAA));
        check("wr_cmd_id", val_t'(cmd_id), val_t'(8'h05));
        check("wr_payload", val_t'(cmd_data[23:0]), val_t'(24'hCCBBAA));
        run_txn(8'h05, 2, 0, 1'b0, 0, val_t'(16'h1234));
        run_txn(8'h05, 2, 1, 1'b0, 0, val_t'(16'h1234));

        // Oversized write is drained; oversized read is refused immediately.
        run_txn(8'h85, 32, 0, 1'b0, 0, '0);
        run_txn(8'h07, 20, 0, 1'b0, 0, '0);
        run_txn(8'h0A, 4, 0, 1'b1, 1, val_t'(32'hDEADBEEF));

        // Reset in the middle of a write payload, with handshakes asserted alongside.
        open_cmd();
        send(8'h81, 0);
        send(8'h03, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        reset        = 1'b1;
        bus.rx_data  = 8'h33;
        bus.rx_valid = 1'b1;
        bus.rd_ack   = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        check_reset_values();
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rd_ack   = 1'b0;
        bus.tx_ready = 1'b0;
        model_reset();
        tick();
        run_txn(8'h81, 3, 0, 1'b0, 0, val_t'(24'h665544));

        // Host stalls after the command byte.
        s0 = strobe_seen;
        e0 = err_seen;
        open_cmd();
        send(8'h83, 0);
        exp_rw = 1'b1;
        exp_id = 7'h03;
`ifdef MONITOR_TIMEOUT_EN
        n = 0;
        while (state != 3'd0 && n < 300) begin
            tick();
            n++;
        end
        check("timeout_cycles", val_t'(n), val_t'(TO_CYC));
        exp_code = 2'd3;
        repeat (2) tick();
        check_regs(0, 1, s0, e0);
`else
        repeat (2*TO_CYC) tick();
        check("no_timeout_len", val_t'(state), val_t'(2));
        send(8'h00, 0);
        exp_size = 8'h00;
        repeat (2) tick();
        check_regs(0, 0, s0, e0);
`endif

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(9, 0));
            pl   = {$urandom, $urandom, $urandom, $urandom};
            rw   = 1'($urandom & 1);
            if (kind <= 3) begin
                rw  = 1'b1;
                len = int'($urandom_range(MAXP, 1));
            end else if (kind <= 6) begin
                rw  = 1'b0;
                len = int'($urandom_range(MAXP, 1));
            end else if (kind == 7) begin
                len = 0;
            end else if (kind == 8) begin
                rw  = 1'b1;
                len = int'($urandom_range(40, MAXP + 1));
            end else begin
                rw  = 1'b0;
                len = int'($urandom_range(255, MAXP + 1));
            end
            run_txn({rw, 7'($urandom)}, len, int'($urandom_range(2, 0)),
                    ($urandom_range(3, 0) == 0), 2, pl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/monitor_cmd_engine.md
MONITOR_CMD_ENGINE -- requirements
Module: monitor_cmd_engine

Interface
REQ-001 Parameter CMD_BYTES, default 1: command field width in bytes (1..4), sent MSB-byte first.
REQ-002 Parameter LEN_BYTES, default 1: length field width in bytes (1..2), sent MSB-byte first.
REQ-003 Parameter MAX_PAYLOAD, default 16: payload buffer depth in bytes (1..64).
REQ-004 Parameter TIMEOUT_CYCLES, default 50000: inter-byte timeout, used only under REQ-040.
REQ-005 clk50  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rx_data  in  8  received byte; rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-008 tx_data  out  8  byte to send; tx_valid  out  1; tx_ready  in  1; transfer when tx_valid && tx_ready.
REQ-009 uart_rts  in  1  active-low host request; uart_cts  out  1  active-low clear-to-send.
REQ-010 cmd_rw  out  1  command MSB (1 = write); cmd_id  out  8*CMD_BYTES-1  remaining command bits.
REQ-011 data_size  out  8*LEN_BYTES  latched length; cmd_data  out  8*MAX_PAYLOAD  payload buffer, byte k at [8k+:8].
REQ-012 wr_strobe  out  1  one-cycle pulse, completed write; cmd_id/data_size/cmd_data valid that cycle.
REQ-013 rd_req  out  1  read request, held until rd_ack; rd_ack  in  1; rd_data  in  8*MAX_PAYLOAD  sampled on rd_ack.
REQ-014 state  out  3  FSM state; err  out  1  one-cycle error pulse; err_code  out  2  last error cause.

Function
REQ-015 States: IDLE=0, CMD=1, LEN=2, WRITE=3, RD_REQ=4, READ=5, DRAIN=6.
REQ-016 IDLE: uart_cts=1; when uart_rts==0 -> CMD, uart_cts=0 next cycle; rx_valid in IDLE ignored.
REQ-017 CMD: shift in CMD_BYTES bytes; after last -> LEN; {cmd_rw,cmd_id} updated only after final byte.
REQ-018 LEN: shift in LEN_BYTES bytes into data_size; after last byte, byte index cleared.
REQ-019 LEN exit: size==0 -> IDLE, no strobe/request; size>MAX_PAYLOAD -> err, err_code=1, write -> DRAIN, read -> IDLE; else write -> WRITE (cmd_data cleared), read -> RD_REQ.
REQ-020 WRITE: each rx_valid stores byte at index, index++; on byte data_size-1 -> IDLE with wr_strobe same cycle as transition.
REQ-021 DRAIN: discard data_size bytes, then -> IDLE; no wr_strobe.
REQ-022 RD_REQ: rd_req=1; on rd_ack latch rd_data into cmd_data, rd_req=0 next cycle, -> READ.
REQ-023 READ: tx_valid=1, tx_data=cmd_data[8*index+:8]; tx_data/tx_valid stable until accepted; on accept index++; accept of byte data_size-1 -> IDLE, tx_valid=0.
REQ-024 READ, tx_ready held high: one byte per cycle, no bubbles.
REQ-025 rx_valid during RD_REQ or READ: byte dropped, err pulse, err_code=2, transfer continues.
REQ-026 uart_cts=0 in CMD, LEN, WRITE, DRAIN; 1 in IDLE, RD_REQ, READ.
REQ-027 Index width $clog2(MAX_PAYLOAD+1); no wrap: terminal compare is index==data_size-1.
REQ-028 cmd_id, data_size, cmd_data hold after return to IDLE until next command overwrites.
REQ-029 err pulses exactly one cycle per event; err_code holds until next error or reset.

Reset
REQ-030 reset asserted in any state, including mid-payload or mid-handshake: next cycle state=IDLE, discarding partial command.
REQ-031 Reset values: uart_cts=1, tx_valid=0, tx_data=0, rd_req=0, wr_strobe=0, err=0, err_code=0, cmd_rw=0, cmd_id=0, data_size=0, cmd_data=0, index=0.
REQ-032 reset overrides rx_valid, tx_ready and rd_ack in the same cycle.

Configuration
REQ-040 Macro MONITOR_TIMEOUT_EN defined: counter cleared on every rx_valid/transfer/state change; in CMD, LEN, WRITE, DRAIN reaching TIMEOUT_CYCLES -> IDLE, err pulse, err_code=3, no wr_strobe.
REQ-041 MONITOR_TIMEOUT_EN undefined: no counter, states wait indefinitely, err_code=3 never produced, TIMEOUT_CYCLES unused.

Verification
REQ-050 Write: rts=0, bytes 0x85,0x03,0xAA,0xBB,0xCC -> wr_strobe once, cmd_id=0x05, data_size=3, cmd_data[23:0]=0xCCBBAA, state IDLE.
REQ-051 Read: 0x05,0x02, rd_ack with rd_data[15:0]=0x1234, tx_ready=1 -> tx bytes 0x34,0x12 on consecutive cycles, then tx_valid=0.
REQ-052 Read with tx_ready toggled 1-of-3 cycles -> tx_data stable while unaccepted, exactly 2 transfers.
REQ-053 Length 0x20 (MAX_PAYLOAD=16) write -> err, err_code=1, 32 bytes drained, no wr_strobe, back to IDLE.
REQ-054 reset after 2 of 3 payload bytes -> IDLE, all REQ-031 values; next full write completes normally.
REQ-055 MONITOR_TIMEOUT_EN, TIMEOUT_CYCLES=100: stop after command byte -> IDLE at cycle 100, err_code=3; undefined: stays in LEN.
